// File: rtl/fmul_param_if.sv
// Operand/result handshake bundle for the parametrised FP multiplier.
// Latency: none; wires only.
// Backpressure: iDATA_BUSY from the consumer, oDATA_BUSY back to the producer.
//
// Signals: request side iDATA_REQ/iDATA_A/iDATA_B/iDATA_RMODE with oDATA_BUSY;
// result side oDATA_VALID/oDATA/oDATA_FLAGS with iDATA_BUSY.
// The slave modport is the multiplier's view; master is the surrounding datapath.
interface fmul_param_if #(
    parameter int DATA_W = 72
);
    logic              iDATA_REQ;
    logic              oDATA_BUSY;
    logic [DATA_W-1:0] iDATA_A;
    logic [DATA_W-1:0] iDATA_B;
    logic [1:0]        iDATA_RMODE;
    logic              oDATA_VALID;
    logic              iDATA_BUSY;
    logic [DATA_W-1:0] oDATA;
    logic [3:0]        oDATA_FLAGS;

    modport slave (
        input  iDATA_REQ, iDATA_A, iDATA_B, iDATA_RMODE, iDATA_BUSY,
        output oDATA_BUSY, oDATA_VALID, oDATA, oDATA_FLAGS
    );

    modport master (
        output iDATA_REQ, iDATA_A, iDATA_B, iDATA_RMODE, iDATA_BUSY,
        input  oDATA_BUSY, oDATA_VALID, oDATA, oDATA_FLAGS
    );
endinterface

// File: rtl/fmul_param.sv
// Parametrised IEEE-754-style multiplier: operand capture, multiply, normalize/round, exception/pack.
// Latency: result valid 3 cycles after the accepting edge; one result per cycle when not stalled.
// Backpressure: a held result with iDATA_BUSY freezes every stage; oDATA_BUSY mirrors that stall.
//
// Ports: iCLOCK, inRESET (async, active low), iRESET_SYNC (sync, active high),
// bus (fmul_param_if.slave) carrying operands, rounding mode, result, flags and both busy lines.
// Flags are {invalid, overflow, underflow, inexact}. Denormal inputs read as zero, tiny results flush to zero.
module fmul_param #(
    parameter int EXP_W   = 11,
    parameter int FRACT_W = 60
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    fmul_param_if.slave bus
);
    localparam int DATA_W = 1 + EXP_W + FRACT_W;
    localparam int PROD_W = 2 * FRACT_W + 2;
    localparam int XE_W   = EXP_W + 2;

    localparam logic signed [XE_W-1:0] BIAS     = XE_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XE_W-1:0] EXP_MAX  = XE_W'((1 << EXP_W) - 1);
    localparam logic signed [XE_W-1:0] EXP_ONE  = XE_W'(1);
    localparam logic signed [XE_W-1:0] EXP_ZERO = '0;

    localparam logic [DATA_W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRACT_W-1){1'b0}}};
    localparam logic [DATA_W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {FRACT_W{1'b0}}};
    localparam logic [DATA_W-2:0] MAXF_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {FRACT_W{1'b1}}};

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;

    typedef struct packed {
        logic nan;   // either operand NaN
        logic snan;  // either operand signalling NaN
        logic inf;   // either operand infinite
        logic zero;  // either operand zero (exp field 0)
    } cls_t;

    logic stall, accept, out_vld;
    logic [DATA_W-1:0] out_dat;
    logic [3:0]        out_flg;

    assign stall           = out_vld & bus.iDATA_BUSY;
    assign accept          = bus.iDATA_REQ & ~stall;
    assign bus.oDATA_BUSY  = stall;
    assign bus.oDATA_VALID = out_vld;
    assign bus.oDATA       = out_dat;
    assign bus.oDATA_FLAGS = out_flg;

    // ---------------- operand capture ----------------
    logic              s1_vld;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [1:0]        s1_rm;

    // ---------------- stage 1: decode and multiply ----------------
    logic [EXP_W-1:0]       ea, eb;
    logic [FRACT_W-1:0]     fa, fb;
    logic                   a_nan, b_nan;
    cls_t                   s1_cls;
    logic [PROD_W-1:0]      s1_prod;
    logic signed [XE_W-1:0] s1_exp;
    logic                   s1_sign;

    assign ea = s1_a[DATA_W-2:FRACT_W];
    assign eb = s1_b[DATA_W-2:FRACT_W];
    assign fa = s1_a[FRACT_W-1:0];
    assign fb = s1_b[FRACT_W-1:0];

    always_comb begin
        a_nan       = (ea == {EXP_W{1'b1}}) && (fa != '0);
        b_nan       = (eb == {EXP_W{1'b1}}) && (fb != '0);
        s1_cls.nan  = a_nan | b_nan;
        s1_cls.snan = (a_nan & ~fa[FRACT_W-1]) | (b_nan & ~fb[FRACT_W-1]);
        s1_cls.inf  = ((ea == {EXP_W{1'b1}}) && (fa == '0)) || ((eb == {EXP_W{1'b1}}) && (fb == '0));
        s1_cls.zero = (ea == '0) || (eb == '0);
    end

    assign s1_prod = PROD_W'({1'b1, fa}) * PROD_W'({1'b1, fb});
    assign s1_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    assign s1_sign = s1_a[DATA_W-1] ^ s1_b[DATA_W-1];

    logic                   s2_vld, s2_sign;
    logic signed [XE_W-1:0] s2_exp;
    logic [PROD_W-1:0]      s2_prod;
    logic [1:0]             s2_rm;
    cls_t                   s2_cls;

    // ---------------- stage 2: normalize and round ----------------
    logic [FRACT_W:0]       mant;
    logic [FRACT_W+1:0]     mant_r;
    logic                   guard, sticky, inc, n_inexact;
    logic signed [XE_W-1:0] n_exp_pre, n_exp_post;
    logic [FRACT_W-1:0]     n_fract;

    always_comb begin
        mant       = s2_prod[PROD_W-2 -: FRACT_W+1];
        guard      = s2_prod[FRACT_W-1];
        sticky     = |s2_prod[FRACT_W-2:0];
        n_exp_pre  = s2_exp;
        inc        = 1'b0;
        // Product in [2,4): take the upper window and bump the exponent.
        if (s2_prod[PROD_W-1]) begin
            mant      = s2_prod[PROD_W-1 -: FRACT_W+1];
            guard     = s2_prod[FRACT_W];
            sticky    = |s2_prod[FRACT_W-1:0];
            n_exp_pre = s2_exp + EXP_ONE;
        end
        n_inexact = guard | sticky;
        case (s2_rm)
            RM_RNE:  inc = guard & (sticky | mant[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~s2_sign & n_inexact;
            default: inc = s2_sign & n_inexact;
        endcase
        mant_r     = {1'b0, mant} + {{(FRACT_W+1){1'b0}}, inc};
        n_fract    = mant_r[FRACT_W-1:0];
        n_exp_post = n_exp_pre;
        // Rounding carried out of the hidden bit: mantissa is exactly 2.0.
        if (mant_r[FRACT_W+1]) begin
            n_fract    = mant_r[FRACT_W:1];
            n_exp_post = n_exp_pre + EXP_ONE;
        end
    end

    logic                   s3_vld, s3_sign, s3_inexact;
    logic signed [XE_W-1:0] s3_exp_pre, s3_exp_post;
    logic [FRACT_W-1:0]     s3_fract;
    logic [1:0]             s3_rm;
    cls_t                   s3_cls;

    // ---------------- stage 3: exceptions and packing ----------------
    logic [DATA_W-1:0] n_dat;
    logic [3:0]        n_flg;
    logic              inf_zero;

    always_comb begin
        inf_zero = s3_cls.inf & s3_cls.zero;
        n_dat    = {s3_sign, s3_exp_post[EXP_W-1:0], s3_fract};
        n_flg    = {3'b000, s3_inexact};
        if (s3_cls.nan || inf_zero) begin
            n_dat = QNAN;
            n_flg = {s3_cls.snan | inf_zero, 3'b000};
        end else if (s3_cls.inf) begin
            n_dat = {s3_sign, INF_MAG};
            n_flg = 4'b0000;
        end else if (s3_cls.zero) begin
            n_dat = {s3_sign, {(DATA_W-1){1'b0}}};
            n_flg = 4'b0000;
        end else if (s3_exp_post >= EXP_MAX) begin
            n_flg = 4'b0101;
            case (s3_rm)
                RM_RNE:  n_dat = {s3_sign, INF_MAG};
                RM_RTZ:  n_dat = {s3_sign, MAXF_MAG};
                RM_RUP:  n_dat = s3_sign ? {1'b1, MAXF_MAG} : {1'b0, INF_MAG};
                default: n_dat = s3_sign ? {1'b1, INF_MAG} : {1'b0, MAXF_MAG};
            endcase
        end else if (s3_exp_pre <= EXP_ZERO) begin
            // Tininess judged on the pre-rounding exponent; flush to zero.
            n_dat = {s3_sign, {(DATA_W-1){1'b0}}};
            n_flg = 4'b0011;
        end
    end

    // Valids and visible outputs: cleared by either reset.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
            out_flg <= '0;
        end else if (iRESET_SYNC) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
            out_flg <= '0;
        end else if (!stall) begin
            s1_vld  <= accept;
            s2_vld  <= s1_vld;
            s3_vld  <= s2_vld;
            out_vld <= s3_vld;
            // Bubbles present all-zero data and flags.
            out_dat <= s3_vld ? n_dat : '0;
            out_flg <= s3_vld ? n_flg : '0;
        end
    end

    // Datapath payload: qualified by the valids above, so no reset needed.
    always_ff @(posedge iCLOCK) begin
        if (!stall) begin
            s1_a        <= bus.iDATA_A;
            s1_b        <= bus.iDATA_B;
            s1_rm       <= bus.iDATA_RMODE;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_prod     <= s1_prod;
            s2_rm       <= s1_rm;
            s2_cls      <= s1_cls;
            s3_sign     <= s2_sign;
            s3_exp_pre  <= n_exp_pre;
            s3_exp_post <= n_exp_post;
            s3_fract    <= n_fract;
            s3_inexact  <= n_inexact;
            s3_rm       <= s2_rm;
            s3_cls      <= s2_cls;
        end
    end
endmodule

// File: tb/tb_fmul_param.sv
// Bench for fmul_param at EXP_W=8, FRACT_W=23 (binary32 layout).
// Directed vectors feed a scoreboard queue; a monitor pops on every result transfer.
// Covers back-to-back issue, rounding modes, specials, stall hold and both resets.
module tb_fmul_param;
    localparam int EW = 8;
    localparam int FW = 23;
    localparam int DW = 32;
    localparam int NV = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic srst  = 1'b0;

    fmul_param_if #(.DATA_W(DW)) bus ();

    fmul_param #(.EXP_W(EW), .FRACT_W(FW)) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (srst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  flg;
        int          cyc;
        logic        chk_lat;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed vectors: A, B, mode, expected result, expected {inv,ovf,unf,inx}.
    logic [31:0] va [NV] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800800, 32'h3F800800, 32'h3F800800,
                             32'hBF800800, 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h7F000000,
                             32'h7F000000, 32'h00800000, 32'h7F800001, 32'h7FC00000, 32'hFF000000,
                             32'hFF000000, 32'h7F000000, 32'hBF800800};
    logic [31:0] vb [NV] = '{32'h40000000, 32'h3FC00000, 32'h3F800800, 32'h3F800800, 32'h3F800800,
                             32'h3F800800, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h7F000000,
                             32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F800000, 32'h7F000000,
                             32'h7F000000, 32'h7F000000, 32'h3F800800};
    logic [1:0]  vr [NV] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                             2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [31:0] vd [NV] = '{32'h40400000, 32'h40100000, 32'h3F801000, 32'h3F801001, 32'h3F801000,
                             32'hBF801001, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF7FFFFF,
                             32'hFF800000, 32'h7F7FFFFF, 32'hBF801000};
    logic [3:0]  vf [NV] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0, 4'h5,
                             4'h5, 4'h3, 4'h8, 4'h0, 4'h5, 4'h5, 4'h5, 4'h1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic send(input int i, input logic lat);
        exp_t e;
        int   g;
        @(negedge clk);
        bus.iDATA_REQ   = 1'b1;
        bus.iDATA_A     = va[i];
        bus.iDATA_B     = vb[i];
        bus.iDATA_RMODE = vr[i];
        #1;
        g = 0;
        while (bus.oDATA_BUSY && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: vector %0d never accepted", i);
        end else begin
            e.dat     = vd[i];
            e.flg     = vf[i];
            e.cyc     = cyc + 4;  // accepting edge is cyc+1, result 3 edges later
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.iDATA_REQ = 1'b0;
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_valid"}, 64'(bus.oDATA_VALID), 64'd0);
        chk({nm, "_data"},  64'(bus.oDATA),       64'd0);
        chk({nm, "_flags"}, 64'(bus.oDATA_FLAGS), 64'd0);
    endtask

    task automatic fill_stalled();
        bus.iDATA_BUSY = 1'b1;
        send(0, 1'b0);
        send(1, 1'b0);
        send(2, 1'b0);
        send(10, 1'b0);
        idle(2);
    endtask

    // Monitor: a result transfers when valid is held and downstream is not busy.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.oDATA_VALID === 1'b1 && bus.iDATA_BUSY === 1'b0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h with nothing pending (cycle %0d)", bus.oDATA, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result_data",  64'(bus.oDATA),       64'(e.dat));
                    chk("result_flags", 64'(bus.oDATA_FLAGS), 64'(e.flg));
                    if (e.chk_lat) chk("result_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.iDATA_REQ   = 1'b0;
        bus.iDATA_A     = '0;
        bus.iDATA_B     = '0;
        bus.iDATA_RMODE = 2'd0;
        bus.iDATA_BUSY  = 1'b0;
        #1;
        chk_cleared("reset_async_t0");
        chk("reset_busy", 64'(bus.oDATA_BUSY), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cleared("reset_release");

        // All vectors back to back: each must appear exactly 3 edges after acceptance.
        for (int i = 0; i < NV; i++) send(i, 1'b1);
        idle(8);
        chk("drain_back_to_back", 64'(sb.size()), 64'd0);
        #1;
        chk_cleared("idle_after_burst");

        // Stall with the pipeline full: outputs hold, new requests are refused.
        fill_stalled();
        @(negedge clk);
        #1;
        chk("stall_busy",  64'(bus.oDATA_BUSY),  64'd1);
        chk("stall_valid", 64'(bus.oDATA_VALID), 64'd1);
        chk("stall_data",  64'(bus.oDATA),       64'h40400000);
        chk("stall_flags", 64'(bus.oDATA_FLAGS), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.iDATA_REQ = 1'b1;
            bus.iDATA_A   = 32'h3F800000;
            bus.iDATA_B   = 32'h3F800000;
            #1;
            chk("stall_hold_data", 64'(bus.oDATA),      64'h40400000);
            chk("stall_hold_busy", 64'(bus.oDATA_BUSY), 64'd1);
        end
        @(negedge clk);
        bus.iDATA_REQ  = 1'b0;
        bus.iDATA_BUSY = 1'b0;
        idle(8);
        chk("drain_after_stall", 64'(sb.size()), 64'd0);

        // Asynchronous reset with a full, stalled pipeline.
        fill_stalled();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cleared("async_reset_now");
        sb.delete();
        @(negedge clk);
        rst_n          = 1'b1;
        bus.iDATA_BUSY = 1'b0;
        idle(6);
        #1;
        chk_cleared("async_reset_no_stale");

        // Synchronous reset: takes effect on the edge, and beats a same-cycle request.
        fill_stalled();
        @(negedge clk);
        srst = 1'b1;
        #1;
        chk("sync_reset_before_edge", 64'(bus.oDATA_VALID), 64'd1);
        @(negedge clk);
        #1;
        chk_cleared("sync_reset_edge");
        sb.delete();
        bus.iDATA_BUSY  = 1'b0;
        bus.iDATA_REQ   = 1'b1;
        bus.iDATA_A     = 32'h3FC00000;
        bus.iDATA_B     = 32'h40000000;
        bus.iDATA_RMODE = 2'd0;
        @(negedge clk);
        srst          = 1'b0;
        bus.iDATA_REQ = 1'b0;
        idle(6);
        #1;
        chk_cleared("sync_reset_no_stale");

        // Pipeline still works after both resets.
        send(5, 1'b1);
        idle(6);
        chk("drain_final", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fmul_param.md
Name: fmul_param

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier; successor of the fixed 72-bit multiplier.
- Exponent and fraction widths are parameters. Rounding mode is selectable per transaction. Per-result exception flags are produced.
- Sits in the FPU datapath between operand issue and writeback.
- Three-stage pipeline: multiply, normalize/round, exception/pack. Valid/busy handshake on both sides.

Parameters:
EXP_W, 11, exponent field width (>=4); bias = 2^(EXP_W-1)-1
FRACT_W, 60, stored fraction width, hidden bit excluded (>=4)
DATA_W, 1+EXP_W+FRACT_W, derived operand/result width; not user-overridable

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous reset, active-high
iDATA_REQ  in  1  input transaction request
oDATA_BUSY  out  1  pipeline stalled; input not accepted
iDATA_A  in  DATA_W  operand A {sign, exp, fract}
iDATA_B  in  DATA_W  operand B
iDATA_RMODE  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf (RUP), 11 toward -inf (RDN)
oDATA_VALID  out  1  result valid
iDATA_BUSY  in  1  downstream cannot accept
oDATA  out  DATA_W  result
oDATA_FLAGS  out  4  {invalid, overflow, underflow, inexact}, qualified by oDATA_VALID

Behaviour:
- Reset: inRESET low asynchronously clears all stage valids, oDATA_VALID, oDATA and oDATA_FLAGS to 0. iRESET_SYNC high does the same on the next edge and overrides a same-cycle input.
- Reset mid-operation drops every in-flight transaction. No result is produced for them.
- Handshake:
  - Global stall stall = oDATA_VALID & iDATA_BUSY. oDATA_BUSY = stall, combinationally.
  - An input is accepted when iDATA_REQ & !oDATA_BUSY.
  - On stall, all stage registers hold, including oDATA, oDATA_FLAGS and oDATA_VALID.
  - Otherwise all stages advance every cycle; a bubble propagates as valid=0.
- Latency and throughput: latency is exactly 3 cycles from the accepting edge to oDATA_VALID=1. Throughput is 1 per cycle with no stall.
- Per-transaction state: iDATA_RMODE is captured with the operands and travels with the transaction.
- Stage 1 (multiply):
  - DAZ: exp=0 operands are treated as zero.
  - Mantissa product is (FRACT_W+1)x(FRACT_W+1) = 2*FRACT_W+2 bits.
  - Exponent = eA+eB-bias in EXP_W+2-bit signed.
  - Sign = sA^sB.
  - Special-case class (NaN, Inf, zero) is decoded and carried.
- Stage 2 (normalize/round):
  - If product MSB=1: shift right 1, exp+1.
  - Keep FRACT_W+1 bits plus guard; sticky = OR of the remaining bits. inexact = guard|sticky.
  - Rounding increment by mode:
    - RNE: increment if guard & (sticky | lsb).
    - RTZ: never increment.
    - RUP: increment if !sign & inexact.
    - RDN: increment if sign & inexact.
  - A mantissa carry-out renormalizes: shift right 1, exp+1.
- Stage 3 (exception/pack), priority high to low:
  - Any NaN operand, or Inf*0: canonical qNaN {0, all-ones, 1 followed by zeros}. invalid=1 only for a signalling NaN or Inf*0.
  - Inf*nonzero: signed Inf, no flags.
  - Either operand zero (after DAZ): signed zero, no flags.
  - Biased exp >= 2^EXP_W-1 is overflow; overflow=1, inexact=1. Result by mode:
    - RNE: signed Inf.
    - RTZ: signed max-finite.
    - RUP: +Inf if positive, -max-finite if negative.
    - RDN: -Inf if negative, +max-finite if positive.
  - Biased exp <= 0 (tininess detected before rounding, FTZ): signed zero, underflow=1, inexact=1.
  - Otherwise: packed normal result; inexact from stage 2.
- Flags are all zero whenever oDATA_VALID=0 after reset. They are held during a stall.

Test Plan (instance EXP_W=8, FRACT_W=23):
- Basic product: A=0x3FC00000, B=0x40000000, RNE -> oDATA=0x40400000, flags=0000 exactly 3 cycles after accept. 8 back-to-back requests -> 8 consecutive valid cycles.
- Rounding tie: A=B=0x3F800800.
  - RNE -> 0x3F801000, inexact=1.
  - RUP -> 0x3F801001.
  - RTZ -> 0x3F801000.
  - Repeat with signs negated: RDN -> 0xBF801001.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
  - 0x00000001*0x3F800000 (DAZ) -> 0x00000000, flags 0.
- Overflow/underflow:
  - 0x7F000000*0x7F000000: RNE -> 0x7F800000, flags 0101; RTZ -> 0x7F7FFFFF.
  - 0x00800000*0x00800000 -> 0x00000000, flags 0011.
- Stall: hold iDATA_BUSY=1 with 3 valid transactions in flight.
  - oDATA_BUSY=1 and oDATA stable.
  - A new iDATA_REQ is ignored.
  - On release, results emerge in order with no loss or duplication.
- Reset: assert inRESET with a full pipeline mid-stall -> oDATA_VALID=0, oDATA=0, flags=0 immediately; no stale result after release. Repeat with iRESET_SYNC, checking the same outputs on the next edge.
